multicycle_pc_controller: RTL
=============================

Name: multicycle_pc_controller

Overview:
- Multicycle sequencer for the RV64 datapath.
- Decides when the program counter register loads and which next-PC source it takes (PC+4 or PC+imm). This replaces the free-running clock-divider load of the PC.
- Drives instruction/data memory handshakes, instruction-register load and register-file write strobes.
- Sits between memories, decoder and the `program_counter` datapath.
- The PC register is clocked by `clk` with `pc_load` as its load enable.

Parameters:
- FETCH_TIMEOUT, 16, max cycles in FETCH waiting for `imem_ready` before a fault (≥2).
- MEM_TIMEOUT, 16, max cycles in MEM waiting for `dmem_ready` before a fault (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enable instruction sequencing.
- opcode  in  7  instr[6:0] from the instruction register.
- zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  one-cycle IR capture strobe.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write (store).
- reg_write  out  1  register-file write strobe.
- mem_to_reg  out  1  writeback source is memory.
- alu_src_imm  out  1  ALU B operand is immediate.
- pc_load  out  1  PC register load enable, one-cycle pulse.
- pc_src  out  1  1 selects PC+imm; meaningful only with `pc_load`.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- fault  out  1  sticky timeout flag.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async, `rst_n` low): state=IDLE, timeout counter=0, `fault`=0, all strobes 0.
- Strobes are Moore outputs decoded from registered state, except that `pc_load`/`ir_load` in wait states also depend on the ready inputs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - `run`=1 → FETCH.
  - Otherwise hold; no strobes.
- FETCH:
  - `imem_req`=1.
  - `imem_ready`=1 → `ir_load`=1 same cycle, → DECODE, counter cleared.
  - Otherwise counter+1.
  - Counter reaching FETCH_TIMEOUT-1 without ready → `fault`=1, → HALT.
- DECODE: one cycle.
  - Opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH) → EXEC.
  - Any other opcode → `illegal`=1, `pc_load`=1, `pc_src`=0, → next state (see end of instruction).
- EXEC: one cycle.
  - `alu_src_imm`=1 for I-ALU, LOAD, STORE.
  - BRANCH: `pc_load`=1, `pc_src`=`zero`, → next state.
  - LOAD/STORE → MEM.
  - R/I-ALU → WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STORE.
  - On `dmem_ready`: LOAD → WB; STORE asserts `pc_load`=1, `pc_src`=0, → next state.
  - Timeout handling identical to FETCH, using MEM_TIMEOUT.
- WB: one cycle.
  - `reg_write`=1; `mem_to_reg`=1 for LOAD.
  - `pc_load`=1, `pc_src`=0, → next state.
- End of instruction ("next state"): `run`=1 → FETCH; otherwise IDLE.
- Invariant: `pc_load` is asserted exactly once per retired instruction.
- Cycles per instruction with zero-wait memory:
  - Branch: 3.
  - ALU: 4.
  - Store: 4.
  - Load: 5.
  - Illegal: 2.
- HALT: no strobes. Exit only by reset. `fault` remains 1.
- `run` deassertion mid-instruction has no effect until the instruction completes.
- Opcode is sampled only in DECODE/EXEC/MEM/WB. The IR is stable after `ir_load`.
- Reset mid-instruction aborts immediately. No `pc_load` is issued.
- Simultaneous ready and timeout-limit cycle: ready wins.

Decomposition:
- Shared package `riscv_ctrl_pkg`:
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - State encoding localparams (3-bit).
- Sub-module `wait_timer`:
  - Clearable up-counter with terminal-count flag, parameterised by limit.
  - Instanced once, shared by FETCH and MEM; cleared on every state change.

Test Plan:
- Reset with `run`=1, `imem_ready`=1, opcode=0110011 → `state` sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH. `reg_write` and `pc_load` high only in WB. `pc_src`=0.
- BRANCH opcode 1100011 with `zero`=1 → `pc_load`=1, `pc_src`=1 in EXEC (cycle 3). Repeat with `zero`=0 → `pc_src`=0.
- LOAD with `dmem_ready` delayed 3 cycles → `dmem_req` held 4 cycles, `dmem_we`=0. WB has `mem_to_reg`=1. Instruction takes 8 cycles.
- Opcode 1111111 → `illegal` and `pc_load` pulse in DECODE, `pc_src`=0, then FETCH.
- `imem_ready` held 0 with FETCH_TIMEOUT=16 → `fault`=1 after 16 FETCH cycles. State stays HALT and ignores `run`, until `rst_n` pulse clears it.
- Drop `run` during EXEC of an ALU op → WB completes with `pc_load`, then IDLE. `rst_n` low during MEM → all outputs 0 asynchronously, no `pc_load`.

Source files
------------

// File: rtl/multicycle_pc_controller_pkg.sv
// riscv_ctrl_pkg: opcode constants, FSM state encoding
// and opcode legality helper for the multicycle sequencer.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    FETCH  = S_FETCH,
    DECODE = S_DECODE,
    EXEC   = S_EXEC,
    MEM    = S_MEM,
    WB     = S_WB,
    HALT   = S_HALT
  } state_t;

  function automatic logic op_legal(
    input logic [6:0] op
  );
    return op inside {
      OP_R, OP_IMM, OP_LOAD,
      OP_STORE, OP_BRANCH
    };
  endfunction

endpackage

// File: rtl/multicycle_pc_controller_if.sv
// Memory handshake bundle: imem_req/imem_ready/ir_load,
// dmem_req/dmem_we/dmem_ready. master = sequencer side.
interface multicycle_pc_controller_if;

  logic imem_req;
  logic imem_ready;
  logic ir_load;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output ir_load,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  ir_load,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );

endinterface

// File: rtl/multicycle_pc_controller_wait_timer.sv
// wait_timer: clearable up-counter; tc flags count==last.
// Ports: clk, rst_n, clr, en, last[W-1:0] -> tc.
module wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/multicycle_pc_controller.sv
// Multicycle sequencer: PC load/source, IR load, mem and
// regfile strobes. Ports: clk, rst_n, run, opcode, zero, mem
// (handshake bundle), writeback/pc strobes, fault, state.
module multicycle_pc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       zero,
  multicycle_pc_controller_if.master mem,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_imm,
  output logic       pc_load,
  output logic       pc_src,
  output logic       illegal,
  output logic       fault,
  output logic [2:0] state
);

  localparam int TMAX =
    (FETCH_TIMEOUT > MEM_TIMEOUT) ?
    FETCH_TIMEOUT : MEM_TIMEOUT;
  localparam int TW = $clog2(TMAX);
  localparam logic [TW-1:0] F_LAST =
    TW'(FETCH_TIMEOUT - 1);
  localparam logic [TW-1:0] M_LAST =
    TW'(MEM_TIMEOUT - 1);

  state_t st;
  state_t nxt;
  state_t done_st;
  logic   tc;
  logic   to;
  logic   is_ld;
  logic   is_st;
  logic   is_br;
  logic   is_imm;

  assign is_ld  = (opcode == OP_LOAD);
  assign is_st  = (opcode == OP_STORE);
  assign is_br  = (opcode == OP_BRANCH);
  assign is_imm = (opcode == OP_IMM);

  // where a retiring instruction hands over
  assign done_st = run ? FETCH : IDLE;

  // one timer serves both wait states; any state
  // change restarts it from zero
  wait_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (nxt != st),
    .en    ((st == FETCH) || (st == MEM)),
    .last  ((st == MEM) ? M_LAST : F_LAST),
    .tc    (tc)
  );

  always_comb begin
    nxt          = st;
    to           = 1'b0;
    mem.imem_req = 1'b0;
    mem.ir_load  = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_imm  = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 1'b0;
    illegal      = 1'b0;
    unique case (st)
      IDLE: begin
        if (run) nxt = FETCH;
      end
      FETCH: begin
        mem.imem_req = 1'b1;
        // ready wins over the timeout cycle
        if (mem.imem_ready) begin
          mem.ir_load = 1'b1;
          nxt         = DECODE;
        end else if (tc) begin
          to  = 1'b1;
          nxt = HALT;
        end
      end
      DECODE: begin
        if (op_legal(opcode)) begin
          nxt = EXEC;
        end else begin
          illegal = 1'b1;
          pc_load = 1'b1;
          nxt     = done_st;
        end
      end
      EXEC: begin
        alu_src_imm = is_imm | is_ld | is_st;
        unique case (1'b1)
          is_br: begin
            pc_load = 1'b1;
            pc_src  = zero;
            nxt     = done_st;
          end
          (is_ld | is_st): nxt = MEM;
          default:         nxt = WB;
        endcase
      end
      MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_st;
        if (mem.dmem_ready) begin
          if (is_st) begin
            pc_load = 1'b1;
            nxt     = done_st;
          end else begin
            nxt = WB;
          end
        end else if (tc) begin
          to  = 1'b1;
          nxt = HALT;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        pc_load    = 1'b1;
        nxt        = done_st;
      end
      HALT: begin
        nxt = HALT;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      fault <= 1'b0;
    end else begin
      st <= nxt;
      if (to) fault <= 1'b1;
    end
  end

  assign state = st;

endmodule
